// File: rtl/mlp_pkg.sv
// Shared definitions for the O/X-detecting MLP: default sizes, derived widths
// and the forward-pass FSM state encoding.
package mlp_pkg;

  localparam int W_DEF    = 8;
  localparam int N_DEF    = 8;
  localparam int FRAC_DEF = 6;

  localparam int HRAW_W  = W_DEF + 5;
  localparam int ACC_O_W = 2 * W_DEF + 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HID,
    ACT,
    OUT,
    FIN
  } state_t;

endpackage

// File: rtl/mlp_sat.sv
// Signed narrowing from IN_W to OUT_W bits.
// MLP_FWD_SAT_EN defined: clamp to the OUT_W range; undefined: keep the low bits (wrap).
module mlp_sat #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

`ifdef MLP_FWD_SAT_EN
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAX_V)
      dout = MAX_V[OUT_W-1:0];
    else if (din < MIN_V)
      dout = MIN_V[OUT_W-1:0];
  end
`else
  logic unused_hi;

  always_comb begin
    dout      = din[OUT_W-1:0];
    unused_hi = ^din[IN_W-1:OUT_W];
  end
`endif

endmodule

// File: rtl/mlp_forward.sv
// Serialized forward pass of the 4x4 O/X MLP: 16 cycles of hidden MACs (all
// neurons in parallel), ReLU, N cycles of output MAC, then score/class/error.
// Optional output saturation selected by MLP_FWD_SAT_EN (see mlp_sat).
module mlp_forward
  import mlp_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           x,
  input  logic signed [W-1:0]   target,
  input  logic [N*16*W-1:0]     w_h_bus,
  input  logic [N*W-1:0]        b_h_bus,
  input  logic [N*W-1:0]        w_o_bus,
  input  logic signed [W-1:0]   b_o_in,
  output logic                  busy,
  output logic                  done,
  output logic signed [W-1:0]   y_out,
  output logic                  class_o,
  output logic signed [W-1:0]   err,
  output logic [N*(W+5)-1:0]    h_act_bus
);

  localparam int HW = W + 5;
  localparam int AW = 2 * W + 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t              state, state_nxt;
  logic [3:0]          j_cnt;
  logic [IW-1:0]       i_cnt;
  logic [15:0]         x_q;
  logic signed [W-1:0] tgt_q;
  logic signed [HW-1:0] acc_h [N];
  logic signed [AW-1:0] acc_o;

  logic signed [HW-1:0] h_sel;
  logic signed [W-1:0]  wo_sel;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] y_full;
  logic signed [W-1:0]  y_nar;
  logic signed [W:0]    err_full;
  logic signed [W-1:0]  err_nar;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = HID;
      HID:  if (j_cnt == 4'd15) state_nxt = ACT;
      ACT:  state_nxt = OUT;
      OUT:  if (i_cnt == IW'(N-1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output MAC reads the registered ReLU values straight from h_act_bus.
  always_comb begin
    h_sel    = h_act_bus[i_cnt*HW +: HW];
    wo_sel   = w_o_bus[i_cnt*W +: W];
    prod     = AW'(h_sel) * AW'(wo_sel);
    y_full   = AW'(b_o_in) + (acc_o >>> FRAC);
    err_full = (W+1)'(tgt_q) - (W+1)'(y_nar);
  end

  mlp_sat #(.IN_W(AW), .OUT_W(W)) u_sat_y (
    .din  (y_full),
    .dout (y_nar)
  );

  mlp_sat #(.IN_W(W+1), .OUT_W(W)) u_sat_err (
    .din  (err_full),
    .dout (err_nar)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      tgt_q     <= '0;
      j_cnt     <= '0;
      i_cnt     <= '0;
      acc_o     <= '0;
      done      <= 1'b0;
      y_out     <= '0;
      class_o   <= 1'b0;
      err       <= '0;
      h_act_bus <= '0;
      for (int unsigned i = 0; i < N; i++)
        acc_h[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          x_q   <= x;
          tgt_q <= target;
          j_cnt <= '0;
          for (int unsigned i = 0; i < N; i++)
            acc_h[i] <= HW'($signed(b_h_bus[i*W +: W]));
        end
        HID: begin
          for (int unsigned i = 0; i < N; i++)
            acc_h[i] <= x_q[j_cnt] ? acc_h[i] + HW'($signed(w_h_bus[(i*16 + j_cnt)*W +: W]))
                                   : acc_h[i] - HW'($signed(w_h_bus[(i*16 + j_cnt)*W +: W]));
          j_cnt <= j_cnt + 4'd1;
        end
        ACT: begin
          for (int unsigned i = 0; i < N; i++)
            h_act_bus[i*HW +: HW] <= acc_h[i][HW-1] ? '0 : acc_h[i];
          acc_o <= '0;
          i_cnt <= '0;
        end
        OUT: begin
          acc_o <= acc_o + prod;
          i_cnt <= i_cnt + 1'b1;
        end
        FIN: begin
          y_out   <= y_nar;
          err     <= err_nar;
          class_o <= !y_nar[W-1] && (y_nar != '0);
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_forward.sv
// Scoreboard bench for mlp_forward: expected results from a behavioural model
// are queued at start and compared (values and done cycle) on each done pulse.
module tb_mlp_forward;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int HB = N * (W + 5);

  typedef struct {
    longint        y;
    longint        err;
    bit            cls;
    logic [HB-1:0] h;
    int            dcyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [15:0]         x;
  logic signed [W-1:0] target;
  logic [N*16*W-1:0]   w_h_bus;
  logic [N*W-1:0]      b_h_bus;
  logic [N*W-1:0]      w_o_bus;
  logic signed [W-1:0] b_o_in;
  logic                busy;
  logic                done;
  logic signed [W-1:0] y_out;
  logic                class_o;
  logic signed [W-1:0] err;
  logic [HB-1:0]       h_act_bus;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  mlp_forward #(.W(W), .N(N), .FRAC(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x         (x),
    .target    (target),
    .w_h_bus   (w_h_bus),
    .b_h_bus   (b_h_bus),
    .w_o_bus   (w_o_bus),
    .b_o_in    (b_o_in),
    .busy      (busy),
    .done      (done),
    .y_out     (y_out),
    .class_o   (class_o),
    .err       (err),
    .h_act_bus (h_act_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic longint narrow(input longint v);
    logic signed [W-1:0] t;
`ifdef MLP_FWD_SAT_EN
    t = '0;
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    t = v[W-1:0];
    return longint'(t);
`endif
  endfunction

  function automatic exp_t model();
    exp_t e;
    longint acc, h, yacc, yfull;
    logic signed [W-1:0] wv;
    yacc = 0;
    e.h  = '0;
    for (int i = 0; i < N; i++) begin
      wv  = b_h_bus[i*W +: W];
      acc = wv;
      for (int j = 0; j < 16; j++) begin
        wv = w_h_bus[(i*16 + j)*W +: W];
        if (x[j]) acc += wv;
        else      acc -= wv;
      end
      h = (acc < 0) ? 0 : acc;
      e.h[i*(W+5) +: (W+5)] = h[W+4:0];
      wv   = w_o_bus[i*W +: W];
      yacc += h * wv;
    end
    yfull  = longint'(b_o_in) + (yacc >>> 6);
    e.y    = narrow(yfull);
    e.err  = narrow(longint'(target) - e.y);
    e.cls  = (e.y > 0);
    e.dcyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.dcyc);
        check("y_out", $signed(y_out), e.y);
        check("err", $signed(err), e.err);
        check("class_o", class_o, e.cls);
        check("h_act_bus", h_act_bus, e.h);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // Called at a negedge; done is expected 28 counter ticks later (latency 27 from the start edge).
  task automatic run_pass(input bit early);
    exp_t e;
    int   c;
    c      = cyc;
    e      = model();
    e.dcyc = c + 28;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (early) begin
      repeat (18) @(negedge clk);
      check("h_act_early", h_act_bus, e.h);
      check("done_early", done, 0);
      check("busy_mid", busy, 1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic fill_bus(input logic [W-1:0] wh, input logic [W-1:0] bh, input logic [W-1:0] wo);
    for (int k = 0; k < N*16; k++) w_h_bus[k*W +: W] = wh;
    for (int k = 0; k < N; k++) begin
      b_h_bus[k*W +: W] = bh;
      w_o_bus[k*W +: W] = wo;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N*16; k++) w_h_bus[k*W +: W] = W'($urandom);
    for (int k = 0; k < N; k++) begin
      b_h_bus[k*W +: W] = W'($urandom);
      w_o_bus[k*W +: W] = W'($urandom);
    end
    x      = 16'($urandom);
    target = W'($urandom);
    b_o_in = W'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_y"}, y_out, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_class"}, class_o, 0);
    check({tag, "_hact"}, h_act_bus, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    exp_t e;
    rst_n  = 1'b0;
    start  = 1'b0;
    x      = '0;
    target = '0;
    b_o_in = '0;
    fill_bus('0, '0, '0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Zero weights: score is just the output bias.
    x = 16'hA5C3; b_o_in = 8'sd5; target = 8'sd10;
    run_pass(1'b1);
    drain();
    check("zero_y", $signed(y_out), 5);
    check("zero_err", $signed(err), 5);
    check("zero_class", class_o, 1);
    check("zero_hact", h_act_bus, 0);

    // All-ones image: y_full = 128 overflows the W-bit score.
    fill_bus(8'h01, 8'h00, 8'h40);
    x = 16'hFFFF; b_o_in = 8'sd0; target = 8'sd0;
    run_pass(1'b1);
    drain();
    check("ones_hact0", h_act_bus[12:0], 16);
    check("ones_hact7", h_act_bus[103:91], 16);
`ifdef MLP_FWD_SAT_EN
    check("ones_y", $signed(y_out), 127);
    check("ones_err", $signed(err), -127);
    check("ones_class", class_o, 1);
`else
    check("ones_y", $signed(y_out), -128);
    check("ones_err", $signed(err), -128);
    check("ones_class", class_o, 0);
`endif

    target = -8'sd128;
    run_pass(1'b0);
    drain();
`ifdef MLP_FWD_SAT_EN
    check("negtgt_err", $signed(err), -128);
`else
    check("negtgt_err", $signed(err), 0);
`endif

    // Blank image: every hidden neuron goes negative and ReLU clips it.
    x = 16'h0000; b_o_in = -8'sd3; target = 8'sd0;
    run_pass(1'b1);
    drain();
    check("blank_y", $signed(y_out), -3);
    check("blank_class", class_o, 0);
    check("blank_hact", h_act_bus, 0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_pass(1'b1);
      drain();
    end

    // start held high: three back-to-back passes, period 28.
    fill_random();
    c = cyc;
    e = model();
    for (int p = 1; p <= 3; p++) begin
      e.dcyc = c + 28 * p;
      sb.push_back(e);
    end
    start = 1'b1;
    repeat (60) @(negedge clk);
    start = 1'b0;
    drain();

    // Extra start pulses while busy must not queue a second pass.
    fill_random();
    run_pass(1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset during HID after a pass left non-zero outputs.
    fill_bus(8'h01, 8'h00, 8'h40);
    x = 16'hFFFF; b_o_in = 8'sd20; target = 8'sd3;
    run_pass(1'b0);
    drain();
    check("pre_abort_y", (y_out != 0), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("abort");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_sb", sb.size(), 0);
    check("abort_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
